// File: rtl/mult_buffer_ctrl_if.sv
// Handshake and buffer-port bundle for mult_buffer_ctrl.
// The controller takes the master side; the environment and buffer take the slave side.
interface mult_buffer_ctrl_if #(
    parameter int IN_W   = 16,
    parameter int ADDR_W = 6
);
    logic                EN_mult;
    logic [IN_W-1:0]     mult_input0;
    logic [IN_W-1:0]     mult_input1;
    logic                RDY_mult;
    logic                EN_writeMem;
    logic [ADDR_W-1:0]   writeMem_addr;
    logic [2*IN_W-1:0]   writeMem_val;
    logic                EN_blockRead;
    logic                EN_readMem;
    logic [ADDR_W-1:0]   readMem_addr;
    logic [2*IN_W-1:0]   readMem_val;
    logic                VALID_memVal;
    logic [2*IN_W-1:0]   memVal_data;
    logic [ADDR_W:0]     count;

    modport master (
        input  EN_mult, mult_input0, mult_input1, EN_blockRead, readMem_val,
        output RDY_mult, EN_writeMem, writeMem_addr, writeMem_val,
               EN_readMem, readMem_addr, VALID_memVal, memVal_data, count
    );

    modport slave (
        output EN_mult, mult_input0, mult_input1, EN_blockRead, readMem_val,
        input  RDY_mult, EN_writeMem, writeMem_addr, writeMem_val,
               EN_readMem, readMem_addr, VALID_memVal, memVal_data, count
    );
endinterface

// File: rtl/mult_buffer_ctrl.sv
// Multiply-and-store front-end: products are written sequentially into an external
// buffer, then streamed back in address order by a block read that empties the buffer.
module mult_buffer_ctrl #(
    parameter int IN_W   = 16,
    parameter int DEPTH  = 64,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst,
    mult_buffer_ctrl_if.master bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PROD_W = 2 * IN_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    function automatic logic [PROD_W-1:0] mult_full(input logic [IN_W-1:0] a,
                                                    input logic [IN_W-1:0] b);
        logic signed [PROD_W-1:0] sa;
        logic signed [PROD_W-1:0] sb;
        logic        [PROD_W-1:0] ua;
        logic        [PROD_W-1:0] ub;
        sa = {{IN_W{a[IN_W-1]}}, a};
        sb = {{IN_W{b[IN_W-1]}}, b};
        ua = {{IN_W{1'b0}}, a};
        ub = {{IN_W{1'b0}}, b};
        if (SIGNED != 0)
            mult_full = sa * sb;
        else
            mult_full = ua * ub;
    endfunction

    logic [1:0]        state;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   rd_len;
    logic [ADDR_W-1:0] rd_ptr;

    logic              vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [PROD_W-1:0] prod_p1;
    logic              rd_vld_p1;

    logic              rdy;
    logic              accept;
    logic              blk;
    logic              rd_last;
    logic [ADDR_W:0]   count_nxt;

    assign rdy       = (state != ST_READ) && (count_r < FULL_CNT);
    assign accept    = bus.EN_mult && rdy;
    assign count_nxt = count_r + (ADDR_W+1)'(accept);
    // A block read in the same cycle as an accept includes that product.
    assign blk       = bus.EN_blockRead && (state != ST_READ) && (count_nxt != '0);
    assign rd_last   = ({1'b0, rd_ptr} == (rd_len - (ADDR_W+1)'(1)));

    assign bus.RDY_mult      = rdy;
    assign bus.EN_writeMem   = vld_p1;
    assign bus.writeMem_addr = wr_addr_p1;
    assign bus.writeMem_val  = prod_p1;
    assign bus.EN_readMem    = (state == ST_READ);
    assign bus.readMem_addr  = rd_ptr;
    assign bus.VALID_memVal  = rd_vld_p1;
    assign bus.memVal_data   = rd_vld_p1 ? bus.readMem_val : '0;
    assign bus.count         = count_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_EMPTY;
            count_r    <= '0;
            rd_len     <= '0;
            rd_ptr     <= '0;
            vld_p1     <= 1'b0;
            wr_addr_p1 <= '0;
            prod_p1    <= '0;
            rd_vld_p1  <= 1'b0;
        end else begin
            // p0 -> p1: product registered; write pointer is count since nothing wraps
            vld_p1    <= accept;
            rd_vld_p1 <= (state == ST_READ);
            if (accept) begin
                wr_addr_p1 <= count_r[ADDR_W-1:0];
                prod_p1    <= mult_full(bus.mult_input0, bus.mult_input1);
            end

            if (state == ST_READ) begin
                if (rd_last) begin
                    state   <= ST_EMPTY;
                    count_r <= '0;
                    rd_ptr  <= '0;
                end else begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
            end else begin
                count_r <= count_nxt;
                if (blk) begin
                    state  <= ST_READ;
                    rd_len <= count_nxt;
                    rd_ptr <= '0;
                end else if (count_nxt == FULL_CNT) begin
                    state <= ST_FULL;
                end else if (count_nxt != '0) begin
                    state <= ST_FILL;
                end else begin
                    state <= ST_EMPTY;
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_buffer_ctrl.sv
// Bench for mult_buffer_ctrl: directed and random traffic against a cycle-level model
// of occupancy, write strobes and block-read streaming; a second instance covers signed mode.
module tb_mult_buffer_ctrl;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mult_buffer_ctrl_if #(.IN_W(16), .ADDR_W(6)) bus ();
    mult_buffer_ctrl_if #(.IN_W(16), .ADDR_W(3)) sbus ();

    mult_buffer_ctrl #(.IN_W(16), .DEPTH(DEPTH), .SIGNED(0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mult_buffer_ctrl #(.IN_W(16), .DEPTH(8), .SIGNED(1)) u_sdut (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    // external buffer: synchronous write, 1-cycle read, write-first on collision
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (bus.EN_writeMem) mem[bus.writeMem_addr] <= bus.writeMem_val;
        if (bus.EN_readMem)
            rd_q <= (bus.EN_writeMem && bus.writeMem_addr == bus.readMem_addr)
                    ? bus.writeMem_val : mem[bus.readMem_addr];
    end
    assign bus.readMem_val  = rd_q;
    assign sbus.readMem_val = '0;

    int err_n = 0;
    int chk_n = 0;

    // reference model state
    int          m_count;
    bit          m_reading;
    int          m_len;
    int          m_rd_next;
    bit          m_wr_pend;
    int          m_wr_addr;
    logic [31:0] m_wr_val;
    bit          m_vld_pend;
    logic [31:0] m_vld_data;
    logic [31:0] exp_mem [DEPTH];

    function automatic logic [31:0] uprod(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    function automatic logic [31:0] sprod(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_n++;
        assert (got === exp) else begin
            err_n++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_reading = 0; m_len = 0; m_rd_next = 0;
        m_wr_pend = 0; m_wr_addr = 0; m_wr_val = '0;
        m_vld_pend = 0; m_vld_data = '0;
    endtask

    // One clock: drive inputs, check this cycle's outputs, advance the model over the edge.
    task automatic tick(input bit em, input logic [15:0] a, input logic [15:0] b, input bit eb);
        bit exp_rdy;
        bit acc;
        bus.EN_mult = em;
        bus.mult_input0 = a;
        bus.mult_input1 = b;
        bus.EN_blockRead = eb;
        #0;
        exp_rdy = !m_reading && (m_count < DEPTH);
        chk("rdy", bus.RDY_mult, exp_rdy);
        chk("count", bus.count, m_count);
        chk("wr_en", bus.EN_writeMem, m_wr_pend);
        if (m_wr_pend) begin
            chk("wr_addr", bus.writeMem_addr, m_wr_addr);
            chk("wr_val", bus.writeMem_val, m_wr_val);
        end
        chk("rd_en", bus.EN_readMem, m_reading);
        if (m_reading) chk("rd_addr", bus.readMem_addr, m_rd_next);
        chk("valid", bus.VALID_memVal, m_vld_pend);
        if (m_vld_pend) chk("data", bus.memVal_data, m_vld_data);

        acc = em && exp_rdy;
        if (!rst) begin
            model_reset();
        end else begin
            m_vld_pend = m_reading;
            if (m_reading) m_vld_data = exp_mem[m_rd_next];
            m_wr_pend = acc;
            if (acc) begin
                m_wr_addr = m_count;
                m_wr_val  = uprod(a, b);
                exp_mem[m_count] = m_wr_val;
            end
            if (m_reading) begin
                if (m_rd_next == m_len - 1) begin
                    m_reading = 0;
                    m_count   = 0;
                end else begin
                    m_rd_next++;
                end
            end else begin
                m_count += int'(acc);
                if (eb && m_count > 0) begin
                    m_reading = 1;
                    m_len     = m_count;
                    m_rd_next = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 16'h0, 16'h0, 0);
    endtask

    task automatic drain(input bit noisy);
        for (int k = 0; k < DEPTH + 4 && m_reading; k++)
            tick(noisy ? bit'($urandom_range(0, 1)) : 1'b0,
                 16'($urandom), 16'($urandom),
                 noisy ? bit'($urandom_range(0, 1)) : 1'b0);
        idle(2);
    endtask

    logic [15:0] sa_tab [6];
    logic [15:0] sb_tab [6];

    initial begin
        bus.EN_mult = 0; bus.mult_input0 = '0; bus.mult_input1 = '0; bus.EN_blockRead = 0;
        sbus.EN_mult = 0; sbus.mult_input0 = '0; sbus.mult_input1 = '0; sbus.EN_blockRead = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tick(0, 16'h0, 16'h0, 0);
        rst = 1'b1;
        idle(1);

        // signed instance: full-width two's-complement products
        sa_tab[0] = 16'hFFFF; sb_tab[0] = 16'h0002;
        sa_tab[1] = 16'h8000; sb_tab[1] = 16'h8000;
        sa_tab[2] = 16'h8000; sb_tab[2] = 16'h7FFF;
        for (int i = 3; i < 6; i++) begin
            sa_tab[i] = 16'($urandom);
            sb_tab[i] = 16'($urandom);
        end
        for (int i = 0; i < 6; i++) begin
            sbus.EN_mult = 1;
            sbus.mult_input0 = sa_tab[i];
            sbus.mult_input1 = sb_tab[i];
            @(posedge clk);
            #1;
            sbus.EN_mult = 0;
            chk("s_wr_en", sbus.EN_writeMem, 1'b1);
            chk("s_wr_addr", sbus.writeMem_addr, i);
            chk("s_wr_val", sbus.writeMem_val, sprod(sa_tab[i], sb_tab[i]));
        end
        chk("s_fixed", sbus.writeMem_val == 32'h0 ? 32'h0 : sprod(16'hFFFF, 16'h0002), 32'hFFFFFFFE);
        chk("s_count", sbus.count, 6);

        // directed unsigned products
        tick(1, 16'd3, 16'd4, 0);
        tick(1, 16'hFFFF, 16'hFFFF, 0);
        tick(1, 16'h0010, 16'h0010, 0);
        chk("wr_val_fixed", bus.writeMem_val, 32'h0000_0100);
        idle(1);
        chk("count3", bus.count, 3);
        tick(0, 16'h0, 16'h0, 1);
        drain(0);

        // fill past capacity, then stream everything back
        for (int i = 0; i < 70; i++) tick(1, 16'($urandom), 16'($urandom), 0);
        chk("full_count", bus.count, 64);
        chk("full_rdy", bus.RDY_mult, 1'b0);
        idle(3);
        tick(0, 16'h0, 16'h0, 1);
        drain(1);
        idle(1);

        // simultaneous accept and block read at count 5
        for (int i = 0; i < 5; i++) tick(1, 16'($urandom), 16'($urandom), 0);
        tick(1, 16'($urandom), 16'($urandom), 1);
        drain(0);
        tick(0, 16'h0, 16'h0, 1);
        idle(3);

        // reset in the middle of a block read
        for (int i = 0; i < 20; i++) tick(1, 16'($urandom), 16'($urandom), 0);
        tick(0, 16'h0, 16'h0, 1);
        idle(10);
        rst = 1'b0;
        tick(0, 16'h0, 16'h0, 0);
        rst = 1'b1;
        tick(1, 16'd7, 16'd9, 0);
        idle(2);

        // random traffic
        for (int i = 0; i < 400; i++)
            tick(bit'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 19) == 0);
        drain(0);

        $display("Result: errors=%0d of %0d checks", err_n, chk_n);
        $finish;
    end
endmodule
